// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, ALU encodings and reset polarity for the ID->EX stage and its
// building blocks.
package id_ex_pipe_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int ALUOP_W_DEF  = 8;
    localparam int ALUFUN_W_DEF = 3;
    localparam int RADDR_W_DEF  = 5;
    localparam int BUBBLE_W     = 16;

    // Reset is asserted when rst equals this value.
    localparam logic RST_ENABLE = 1'b0;

    localparam logic [BUBBLE_W-1:0] BUBBLE_MAX = '1;

    // ALU result selector carried on the alufun field.
    typedef enum logic [ALUFUN_W_DEF-1:0] {
        ALUSEL_NOP   = 3'b000,
        ALUSEL_LOGIC = 3'b001,
        ALUSEL_SHIFT = 3'b010,
        ALUSEL_MOVE  = 3'b011,
        ALUSEL_ARITH = 3'b100
    } alu_sel_e;

    // A few opcodes of the aluop field.
    localparam logic [ALUOP_W_DEF-1:0] EXE_NOP_OP = 8'h00;
    localparam logic [ALUOP_W_DEF-1:0] EXE_AND_OP = 8'h24;
    localparam logic [ALUOP_W_DEF-1:0] EXE_OR_OP  = 8'h25;
    localparam logic [ALUOP_W_DEF-1:0] EXE_XOR_OP = 8'h26;
    localparam logic [ALUOP_W_DEF-1:0] EXE_ADD_OP = 8'h20;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Valid/ready bus of the ID->EX stage: decoder-side inputs and EX-side outputs.
interface id_ex_pipe_if
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int ALUFUN_W = ALUFUN_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF
) ();

    logic                in_valid;
    logic                in_ready;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [ALUFUN_W-1:0] id_alufun;
    logic [XLEN-1:0]     id_reg1;
    logic [XLEN-1:0]     id_reg2;
    logic [RADDR_W-1:0]  id_wd;
    logic                id_wreg;

    logic                out_valid;
    logic                out_ready;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUFUN_W-1:0] ex_alufun;
    logic [XLEN-1:0]     ex_reg1;
    logic [XLEN-1:0]     ex_reg2;
    logic [RADDR_W-1:0]  ex_wd;
    logic                ex_wreg;

    // master: the decoder plus EX consumer around the stage; slave: the stage.
    modport master (
        output in_valid, id_aluop, id_alufun, id_reg1, id_reg2, id_wd, id_wreg, out_ready,
        input  in_ready, out_valid, ex_aluop, ex_alufun, ex_reg1, ex_reg2, ex_wd, ex_wreg
    );

    modport slave (
        input  in_valid, id_aluop, id_alufun, id_reg1, id_reg2, id_wd, id_wreg, out_ready,
        output in_ready, out_valid, ex_aluop, ex_alufun, ex_reg1, ex_reg2, ex_wd, ex_wreg
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic W-bit valid/ready register slice: a 2-entry skid buffer with a
// registered in_ready (SKID=1) or a single pass-through entry (SKID=0).
module pipe_skid_buf
    import id_ex_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid_reg;
    logic [W-1:0] m_data_reg;
    logic         accept;
    logic         consume;

    assign accept    = in_valid & in_ready;
    assign consume   = m_valid_reg & out_ready;
    assign out_valid = m_valid_reg;
    assign out_data  = m_data_reg;

    generate
        if (SKID) begin : g_skid
            // Occupancy encoded as {S.valid, M.valid}.
            localparam logic [1:0] ST_EMPTY = 2'b00;
            localparam logic [1:0] ST_ONE   = 2'b01;
            localparam logic [1:0] ST_FULL  = 2'b11;

            logic         s_valid_reg;
            logic [W-1:0] s_data_reg;

            assign in_ready = !s_valid_reg;

            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                    s_valid_reg <= 1'b0;
                    s_data_reg  <= '0;
                end else if (flush) begin
                    m_valid_reg <= 1'b0;
                    s_valid_reg <= 1'b0;
                end else begin
                    case ({s_valid_reg, m_valid_reg})
                        ST_EMPTY: begin
                            if (accept) begin
                                m_valid_reg <= 1'b1;
                                m_data_reg  <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (accept && consume) begin
                                m_data_reg <= in_data;
                            end else if (accept) begin
                                s_valid_reg <= 1'b1;
                                s_data_reg  <= in_data;
                            end else if (consume) begin
                                m_valid_reg <= 1'b0;
                            end
                        end
                        ST_FULL: begin
                            if (consume) begin
                                m_data_reg  <= s_data_reg;
                                s_valid_reg <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = out_ready | !m_valid_reg;

            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                end else if (flush) begin
                    m_valid_reg <= 1'b0;
                end else if (accept) begin
                    m_valid_reg <= 1'b1;
                    m_data_reg  <= in_data;
                end else if (consume) begin
                    m_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage: packs the decoded fields into a skid buffer, gates
// the write enable with out_valid and counts empty output cycles.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int ALUFUN_W = ALUFUN_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter bit SKID     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_ex_pipe_if.slave         bus,
    output logic [BUBBLE_W-1:0] bubble_cnt
);

    localparam int W = ALUOP_W + ALUFUN_W + 2 * XLEN + RADDR_W + 1;

    logic [W-1:0]        in_data;
    logic [W-1:0]        out_data;
    logic                out_valid_int;
    logic                wreg_raw;
    logic [BUBBLE_W-1:0] bubble_cnt_reg;

    assign in_data = {bus.id_aluop, bus.id_alufun, bus.id_reg1, bus.id_reg2,
                      bus.id_wd, bus.id_wreg};

    pipe_skid_buf #(
        .W    (W),
        .SKID (SKID)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (out_valid_int),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign {bus.ex_aluop, bus.ex_alufun, bus.ex_reg1, bus.ex_reg2,
            bus.ex_wd, wreg_raw} = out_data;
    assign bus.out_valid = out_valid_int;
    // A stale or flushed entry must never write the register file.
    assign bus.ex_wreg   = out_valid_int & wreg_raw;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            bubble_cnt_reg <= '0;
        end else if (!out_valid_int && bubble_cnt_reg != BUBBLE_MAX) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a FIFO-of-capacity-2 reference model fed by
// the stimulus process, checked every cycle by an independent monitor.
module tb_id_ex_pipe;
    import id_ex_pipe_pkg::*;

    localparam bit TB_SKID = 1'b1;

    typedef struct packed {
        logic [ALUOP_W_DEF-1:0]  aluop;
        logic [ALUFUN_W_DEF-1:0] alufun;
        logic [XLEN_DEF-1:0]     reg1;
        logic [XLEN_DEF-1:0]     reg2;
        logic [RADDR_W_DEF-1:0]  wd;
        logic                    wreg;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] bubble_cnt;

    id_ex_pipe_if bus ();

    id_ex_pipe #(
        .XLEN     (XLEN_DEF),
        .ALUOP_W  (ALUOP_W_DEF),
        .ALUFUN_W (ALUFUN_W_DEF),
        .RADDR_W  (RADDR_W_DEF),
        .SKID     (TB_SKID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    instr_t      exp_q[$];
    logic [15:0] bub_model = 16'd0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t rnd_instr();
        instr_t t;
        t.aluop  = 8'($urandom);
        t.alufun = 3'($urandom);
        t.reg1   = $urandom;
        t.reg2   = $urandom;
        t.wd     = 5'($urandom);
        t.wreg   = 1'($urandom_range(0, 1));
        return t;
    endfunction

    function automatic instr_t mk(input logic [4:0] wd, input logic [31:0] r1);
        instr_t t;
        t      = rnd_instr();
        t.wd   = wd;
        t.reg1 = r1;
        t.wreg = 1'b1;
        return t;
    endfunction

    // One clock of stimulus. The model's own occupancy decides in_ready and
    // therefore whether the offered instruction is taken.
    task automatic cycle(input logic r, input logic iv, input instr_t d,
                         input logic ordy, input logic fl, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        {bus.id_aluop, bus.id_alufun, bus.id_reg1, bus.id_reg2, bus.id_wd, bus.id_wreg} = d;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        exp_rdy = TB_SKID ? (exp_q.size() < 2) : (ordy || exp_q.size() == 0);
        if (mon_en) check("in_ready", bus.in_ready, exp_rdy);
        acc = iv && exp_rdy;
        #2;
        if (!r || fl) exp_q.delete();
        else if (acc) exp_q.push_back(d);
    endtask

    task automatic send(input instr_t d, input logic ordy);
        logic acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, 1'b1, d, ordy, 1'b0, acc);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: wd=%0d never accepted, expected acceptance", d.wd);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, '0, ordy, 1'b0, acc);
    endtask

    // Monitor: compares the DUT outputs with the head of the model every cycle.
    initial begin
        forever begin
            bit was_empty;
            @(negedge clk);
            #2;
            if (mon_en) begin
                was_empty = (exp_q.size() == 0);
                check("out_valid", bus.out_valid, !was_empty);
                if (!was_empty) begin
                    check("ex_fields", {bus.ex_aluop, bus.ex_alufun, bus.ex_reg1, bus.ex_reg2,
                                        bus.ex_wd, bus.ex_wreg}, exp_q[0]);
                    if (bus.out_ready) begin
                        $display("consume wd=%0d reg1=%h aluop=%h wreg=%0b",
                                 bus.ex_wd, bus.ex_reg1, bus.ex_aluop, bus.ex_wreg);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    check("ex_wreg_idle", bus.ex_wreg, 1'b0);
                end
                check("bubble_cnt", bubble_cnt, bub_model);
                if (!rst) bub_model = 16'd0;
                else if (was_empty && bub_model != 16'hFFFF) bub_model = bub_model + 16'd1;
            end
        end
    end

    initial begin
        logic acc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        {bus.id_aluop, bus.id_alufun, bus.id_reg1, bus.id_reg2, bus.id_wd, bus.id_wreg} = '0;

        // Reset held 3 cycles with a valid instruction offered.
        cycle(1'b0, 1'b1, rnd_instr(), 1'b1, 1'b0, acc);
        mon_en = 1'b1;
        cycle(1'b0, 1'b1, rnd_instr(), 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b1, rnd_instr(), 1'b1, 1'b0, acc);

        // Idle after reset: bubble_cnt reaches 5.
        idle(5, 1'b1);

        // Back-to-back streaming.
        for (int i = 0; i < 4; i++) send(mk(5'(i + 1), 32'h10 + i), 1'b1);
        idle(3, 1'b1);

        // Back-pressure: 5 and 6 fill the stage, 7 waits upstream.
        send(mk(5'd5, 32'h50), 1'b0);
        send(mk(5'd6, 32'h60), 1'b0);
        cycle(1'b1, 1'b1, mk(5'd7, 32'h70), 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b1, mk(5'd7, 32'h70), 1'b0, 1'b0, acc);
        send(mk(5'd7, 32'h70), 1'b1);
        idle(4, 1'b1);

        // Flush while FULL with wd=10 on the input.
        send(mk(5'd8, 32'h80), 1'b0);
        send(mk(5'd9, 32'h90), 1'b0);
        cycle(1'b1, 1'b1, mk(5'd10, 32'hA0), 1'b0, 1'b1, acc);
        idle(4, 1'b1);

        // Simultaneous accept and consume.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, rnd_instr(), 1'b1, 1'b0, acc);
        idle(3, 1'b1);

        // Randomized traffic with random back-pressure and occasional flush.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'b1, $urandom_range(0, 3) != 0, rnd_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, acc);
        end
        idle(4, 1'b1);

        // Long idle run to saturate the bubble counter.
        idle(70000, 1'b1);
        @(negedge clk);
        #4;
        check("bubble_sat", bubble_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
Parametrised ID→EX pipeline stage with a valid/ready handshake, a 2-entry skid buffer and a flush.
- Replaces the free-running ID/EX latch so that EX back-pressure (multi-cycle ALU, memory stalls) no longer drops or duplicates instructions.
- Branch-mispredict flush kills in-flight entries.
- Sits between the decoder (upstream) and the ALU/EX stage (downstream).

Parameters:
XLEN, 32, width of operand buses reg1/reg2
ALUOP_W, 8, width of ALU opcode field
ALUFUN_W, 3, width of ALU function field
RADDR_W, 5, width of destination register address
SKID, 1, 1 = 2-entry skid buffer (in_ready is registered); 0 = single entry (in_ready = out_ready || !out_valid)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
flush  in  1  kill all held entries and the current input
in_valid  in  1  ID presents a valid instruction
in_ready  out  1  stage can accept this cycle
id_aluop  in  ALUOP_W  ALU opcode
id_alufun  in  ALUFUN_W  ALU function
id_reg1  in  XLEN  operand 1
id_reg2  in  XLEN  operand 2
id_wd  in  RADDR_W  destination register
id_wreg  in  1  register write enable
out_valid  out  1  EX outputs hold a valid instruction
out_ready  in  1  EX consumes this cycle
ex_aluop  out  ALUOP_W  registered opcode
ex_alufun  out  ALUFUN_W  registered function
ex_reg1  out  XLEN  registered operand 1
ex_reg2  out  XLEN  registered operand 2
ex_wd  out  RADDR_W  registered destination
ex_wreg  out  1  registered write enable, forced 0 whenever out_valid=0
bubble_cnt  out  16  count of cycles with out_valid=0 after reset, saturating

Behaviour:
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready. All state changes at posedge clk.
- Reset (rst=0 at the edge):
  - out_valid=0; skid entry invalid; in_ready=1.
  - All ex_* fields = 0; bubble_cnt=0.
  - Reset overrides flush and any handshake in progress.
- Latency: one cycle from accept to out_valid when the stage is empty.
- SKID=1 states, each with main (output) reg M and skid reg S:
  - EMPTY: M invalid, S invalid.
    - accept → ONE, M ← input.
  - ONE: M valid, S invalid.
    - accept & consume → ONE, M ← input.
    - accept & !consume → FULL, S ← input.
    - consume & !accept → EMPTY.
    - no accept, no consume → hold.
  - FULL: M valid, S valid.
    - consume → ONE, M ← S.
    - else hold.
    - in_ready=0 in FULL, so accept is impossible.
  - in_ready = !S.valid (registered, no combinational path from out_ready).
- SKID=0: M only. in_ready = out_ready | !out_valid.
- Flush (rst=1, flush=1): next cycle M and S invalid (EMPTY), ex_wreg=0. The input on the flush cycle is discarded even if in_valid=1. ex_* data fields may hold stale values but are don't-care while out_valid=0.
- Ordering: strict FIFO. No instruction is lost or duplicated under any pattern of out_ready toggling.
- Holding: while out_valid=1 & !out_ready, all ex_* outputs are stable.
- bubble_cnt: increments each cycle out_valid=0, saturates at 0xFFFF, cleared only by reset.

Decomposition:
- Shared package/defines: ALU opcode/function widths and encodings, RADDR_W, XLEN, and the RstEnable value (now 1'b0).
- Sub-module: pipe_skid_buf, a generic width-W 2-entry valid/ready skid buffer.
  - id_ex_pipe concatenates the ID fields into one bus, instantiates it, and adds flush, the wreg gating and bubble_cnt.
  - pipe_skid_buf is reused for the EX→MEM stage.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, ex_wreg=0, in_ready=1, bubble_cnt=0 after release.
2. Streaming: out_ready=1, send 4 instructions (wd=1..4, reg1=0x10..0x13) back-to-back → each appears 1 cycle after accept, in order, out_valid continuous.
3. Back-pressure: SKID=1, send wd=5,6,7 while out_ready=0 → wd=5 and wd=6 are accepted, in_ready drops after the second accept, wd=7 is held upstream. Release out_ready → 5, 6, 7 emerge in order, no loss or duplicates.
4. Flush in FULL: with wd=8,9 held and in_valid=1 carrying wd=10, assert flush for 1 cycle → next cycle out_valid=0, ex_wreg=0, in_ready=1, and 10 never appears.
5. Simultaneous accept and consume in ONE: out_ready=1, in_valid=1 every cycle → state stays ONE, throughput 1/cycle.
6. bubble_cnt: idle 5 cycles after reset → 5. Force 70000 idle cycles → saturates at 0xFFFF.
